// File: rtl/gray_ptr_sync_if.sv
// Bundle of the Gray pointer input, error clear and all synchroniser outputs.
// master drives the source pointer and clear; slave is the synchroniser itself.
interface gray_ptr_sync_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int ERR_CNT_W  = 8
);
  logic [ADDR_WIDTH:0]  i_gray;
  logic                 i_err_clr;
  logic [ADDR_WIDTH:0]  o_gray;
  logic [ADDR_WIDTH:0]  o_bin;
  logic                 o_chg;
  logic                 o_err;
  logic [ERR_CNT_W-1:0] o_err_cnt;
  logic                 o_ready;

  modport master (
    output i_gray, i_err_clr,
    input  o_gray, o_bin, o_chg, o_err, o_err_cnt, o_ready
  );

  modport slave (
    input  i_gray, i_err_clr,
    output o_gray, o_bin, o_chg, o_err, o_err_cnt, o_ready
  );
endinterface

// File: rtl/gray_ptr_sync.sv
// Destination-domain synchroniser for async FIFO Gray pointers: N-flop chain,
// registered Gray-to-binary, single-step change strobe and illegal-jump tracking.
module gray_ptr_sync #(
  parameter int ADDR_WIDTH = 3,
  parameter int STAGES     = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rstn,
  gray_ptr_sync_if.slave  bus
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int WW = $clog2(STAGES + 2);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("gray_ptr_sync: STAGES must be 2 or more");
    end
  endgenerate

  logic [PW-1:0]        sync_q [STAGES];
  logic [PW-1:0]        g_q;
  logic [PW-1:0]        bin_q;
  logic [PW-1:0]        bin_next;
  logic [PW-1:0]        diff;
  logic [WW-1:0]        warm_cnt;
  logic                 ready_q;
  logic                 chg_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 single_step;
  logic                 multi_step;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.i_gray;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Binary bit k is the XOR of all Gray bits from the MSB down to k.
  always_comb begin
    bin_next = '0;
    for (int k = 0; k < PW; k++) bin_next[k] = ^(sync_q[STAGES-1] >> k);
  end

  assign diff        = sync_q[STAGES-1] ^ g_q;
  assign single_step = ($countones(diff) == 1);
  assign multi_step  = ($countones(diff) > 1);

  // Ready rises once the chain and compare register hold post-reset samples,
  // so the reset-zero history can never be mistaken for a pointer jump.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      warm_cnt <= '0;
      ready_q  <= 1'b0;
    end else if (!ready_q) begin
      if (warm_cnt == WW'(STAGES)) ready_q <= 1'b1;
      else                         warm_cnt <= warm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g_q   <= '0;
      bin_q <= '0;
    end else begin
      g_q   <= sync_q[STAGES-1];
      bin_q <= bin_next;
    end
  end

  // A new illegal jump takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chg_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      chg_q <= ready_q && single_step;
      if (ready_q && multi_step) begin
        err_q <= 1'b1;
        if (bus.i_err_clr)   err_cnt_q <= ERR_CNT_W'(1);
        else if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
      end else if (bus.i_err_clr) begin
        err_q     <= 1'b0;
        err_cnt_q <= '0;
      end
    end
  end

  assign bus.o_gray    = sync_q[STAGES-1];
  assign bus.o_bin     = bin_q;
  assign bus.o_chg     = chg_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = err_cnt_q;
  assign bus.o_ready   = ready_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench for gray_ptr_sync (ADDR_WIDTH=3, STAGES=2): directed pointer
// steps push expected results, a negedge monitor pops them whenever o_bin moves.
module tb_gray_ptr_sync;

  typedef struct {
    logic [3:0] bin;
    logic       chg;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int   checks     = 0;
  int   errors     = 0;
  int   chg_pulses = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic       tb_err = 1'b0;
  logic [7:0] tb_cnt = 8'd0;
  logic [3:0] prev_bin   = 4'd0;
  logic       prev_ready = 1'b0;
  logic [3:0] gtab [16];

  gray_ptr_sync_if #(.ADDR_WIDTH(3), .ERR_CNT_W(8)) bus ();

  gray_ptr_sync #(.ADDR_WIDTH(3), .STAGES(2), .ERR_CNT_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; holds the new pointer for four cycles, optionally
  // raising the clear on the edge where the step gets classified.
  task automatic applyStimulus(input logic [3:0] gray, input logic [3:0] bin,
                               input logic illegal, input logic clr);
    exp_t e;
    bus.i_gray = gray;
    if (illegal) begin
      tb_err = 1'b1;
      tb_cnt = clr ? 8'd1 : ((tb_cnt == 8'hff) ? tb_cnt : tb_cnt + 8'd1);
    end else if (clr) begin
      tb_err = 1'b0;
      tb_cnt = 8'd0;
    end
    e.bin = bin;
    e.chg = !illegal;
    e.err = tb_err;
    e.cnt = tb_cnt;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    bus.i_err_clr = clr;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_bin   = 4'd0;
      prev_ready = 1'b0;
    end else begin
      if (bus.o_chg) chg_pulses++;
      if (prev_ready && bus.o_bin != prev_bin) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: got o_bin %0h, expected no output", bus.o_bin);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_bin", bus.o_bin, mon_e.bin);
          checkOutput("sb_chg", bus.o_chg, mon_e.chg);
          checkOutput("sb_err", bus.o_err, mon_e.err);
          checkOutput("sb_cnt", bus.o_err_cnt, mon_e.cnt);
        end
      end else if (prev_ready && bus.o_chg) begin
        checkOutput("sb_spurious_chg", bus.o_chg, 1'b0);
      end
      prev_bin   = bus.o_bin;
      prev_ready = bus.o_ready;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    bus.i_gray    = 4'b0110;
    bus.i_err_clr = 1'b0;

    $display("[TB] reset hold with i_gray=0110");
    repeat (3) @(negedge clk);
    checkOutput("rst_gray",  bus.o_gray,    4'd0);
    checkOutput("rst_bin",   bus.o_bin,     4'd0);
    checkOutput("rst_chg",   bus.o_chg,     1'b0);
    checkOutput("rst_err",   bus.o_err,     1'b0);
    checkOutput("rst_cnt",   bus.o_err_cnt, 8'd0);
    checkOutput("rst_ready", bus.o_ready,   1'b0);
    rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput("warm_ready_e1", bus.o_ready, 1'b0);
    @(posedge clk); #1;
    checkOutput("warm_ready_e2", bus.o_ready, 1'b0);
    @(posedge clk); #1;
    checkOutput("warm_ready_e3", bus.o_ready, 1'b1);
    checkOutput("warm_bin",      bus.o_bin,   4'd4);
    checkOutput("warm_err",      bus.o_err,   1'b0);
    checkOutput("warm_chg",      bus.o_chg,   1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("held_chg", bus.o_chg, 1'b0);
    checkOutput("held_err", bus.o_err, 1'b0);
    @(negedge clk);
    applyStimulus(4'b0010, 4'd3, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'd0, 1'b0, 1'b0);

    $display("[TB] single step 0000->0001");
    chg_pulses = 0;
    bus.i_gray = 4'b0001;
    e.bin = 4'd1; e.chg = 1'b1; e.err = 1'b0; e.cnt = 8'd0;
    sb.push_back(e);
    @(posedge clk); #1;
    checkOutput("step_gray_n1", bus.o_gray, 4'b0000);
    @(posedge clk); #1;
    checkOutput("step_gray_n2", bus.o_gray, 4'b0001);
    checkOutput("step_bin_n2",  bus.o_bin,  4'd0);
    checkOutput("step_chg_n2",  bus.o_chg,  1'b0);
    @(posedge clk); #1;
    checkOutput("step_bin_n3",  bus.o_bin,  4'd1);
    checkOutput("step_chg_n3",  bus.o_chg,  1'b1);
    @(posedge clk); #1;
    checkOutput("step_chg_n4",  bus.o_chg,  1'b0);
    @(negedge clk);

    $display("[TB] full Gray wrap");
    for (int i = 2; i < 16; i++) applyStimulus(gtab[i], 4'(i), 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'd0, 1'b0, 1'b0);
    checkOutput("wrap_pulses", chg_pulses, 16);
    checkOutput("wrap_err",    bus.o_err,  1'b0);

    $display("[TB] illegal jump 0000->0011");
    bus.i_gray = 4'b0011;
    tb_err = 1'b1;
    tb_cnt = 8'd1;
    e.bin = 4'd2; e.chg = 1'b0; e.err = 1'b1; e.cnt = 8'd1;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("jump_bin", bus.o_bin,     4'd2);
    checkOutput("jump_chg", bus.o_chg,     1'b0);
    checkOutput("jump_err", bus.o_err,     1'b1);
    checkOutput("jump_cnt", bus.o_err_cnt, 8'd1);
    @(negedge clk);
    for (int k = 1; k <= 300; k++) begin
      if (k % 2 == 1) applyStimulus(4'b0000, 4'd0, 1'b1, 1'b0);
      else            applyStimulus(4'b0011, 4'd2, 1'b1, 1'b0);
    end
    checkOutput("sat_cnt", bus.o_err_cnt, 8'd255);
    checkOutput("sat_err", bus.o_err,     1'b1);

    $display("[TB] error clear interplay");
    bus.i_err_clr = 1'b1;
    @(posedge clk); #1;
    checkOutput("clr_err", bus.o_err,     1'b0);
    checkOutput("clr_cnt", bus.o_err_cnt, 8'd0);
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    tb_err = 1'b0;
    tb_cnt = 8'd0;
    applyStimulus(4'b0000, 4'd0, 1'b1, 1'b0);
    applyStimulus(4'b0011, 4'd2, 1'b1, 1'b1);
    checkOutput("clrset_err", bus.o_err,     1'b1);
    checkOutput("clrset_cnt", bus.o_err_cnt, 8'd1);

    $display("[TB] mid-operation reset");
    applyStimulus(4'b0111, 4'd5, 1'b0, 1'b0);
    checkOutput("pre_rst_bin", bus.o_bin, 4'd5);
    checkOutput("pre_rst_err", bus.o_err, 1'b1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("mid_rst_gray",  bus.o_gray,    4'd0);
    checkOutput("mid_rst_bin",   bus.o_bin,     4'd0);
    checkOutput("mid_rst_err",   bus.o_err,     1'b0);
    checkOutput("mid_rst_cnt",   bus.o_err_cnt, 8'd0);
    checkOutput("mid_rst_ready", bus.o_ready,   1'b0);
    #1 rstn = 1'b1;
    tb_err = 1'b0;
    tb_cnt = 8'd0;
    @(posedge clk); #1;
    checkOutput("rewarm_ready_e1", bus.o_ready, 1'b0);
    @(posedge clk); #1;
    checkOutput("rewarm_ready_e2", bus.o_ready, 1'b0);
    @(posedge clk); #1;
    checkOutput("rewarm_ready_e3", bus.o_ready, 1'b1);
    checkOutput("rewarm_bin",      bus.o_bin,   4'd5);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput("rewarm_err", bus.o_err, 1'b0);
      checkOutput("rewarm_chg", bus.o_chg, 1'b0);
    end

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
